// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// sharing one accumulator/shift datapath, one bit per cycle.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [2:0]        OP_MUL   = 3'b000;
    localparam logic [2:0]        OP_MULHSU = 3'b010;
    localparam logic [2:0]        OP_MULHU = 3'b011;
    localparam logic [2:0]        OP_REM   = 3'b110;
    localparam logic [XLEN-1:0]   ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   SMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]   ONE_W    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_2W   = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [4:0]        LAST_IT  = 5'd31;

    function automatic logic [XLEN-1:0] f_neg_w(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + ONE_W) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] f_neg_2w(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + ONE_2W) : v;
    endfunction

    function automatic logic [XLEN-1:0] f_abs(input logic [XLEN-1:0] v, input logic is_signed);
        return f_neg_w(v, is_signed & v[XLEN-1]);
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_cnt;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic            r_neg;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_result;

    // Start decode: operand signedness, result sign and the single-cycle fast paths
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_neg;
    logic            w_div0;
    logic            w_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_res;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_accept;

    assign w_is_div   = funct3[2];
    assign w_a_signed = w_is_div ? ~funct3[0] : (funct3 != OP_MULHU);
    assign w_b_signed = w_is_div ? ~funct3[0] : ~funct3[1];
    assign w_neg      = (funct3 == OP_REM) ? rs1[XLEN-1]
                      : ((w_a_signed & rs1[XLEN-1]) ^ (w_b_signed & rs2[XLEN-1]));
    assign w_div0     = w_is_div && (rs2 == '0);
    assign w_ovf      = w_is_div && !funct3[0] && (rs1 == SMIN) && (rs2 == ONES);
    assign w_fast     = w_div0 | w_ovf;
    assign w_fast_res = w_div0 ? (funct3[1] ? rs1 : ONES)
                               : (funct3[1] ? '0 : SMIN);
    assign w_abs_a    = f_abs(rs1, w_a_signed);
    assign w_abs_b    = f_abs(rs2, w_b_signed);
    assign w_accept   = start && !flush && ((r_state == S_IDLE) || (r_state == S_FINISH));

    // One iteration of the shared datapath
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN-1:0]   w_mul_acc_nxt;
    logic [XLEN-1:0]   w_mul_lo_nxt;
    logic [XLEN:0]     w_div_sh;
    logic [XLEN:0]     w_div_diff;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_acc_nxt;
    logic [XLEN-1:0]   w_div_lo_nxt;
    logic [XLEN-1:0]   w_acc_nxt;
    logic [XLEN-1:0]   w_lo_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    assign w_mul_sum     = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
    assign w_mul_acc_nxt = w_mul_sum[XLEN:1];
    assign w_mul_lo_nxt  = {w_mul_sum[0], r_lo[XLEN-1:1]};

    // Remainder stays below the divisor, so the 33-bit difference sign is exact
    assign w_div_sh      = {r_acc, r_lo[XLEN-1]};
    assign w_div_diff    = w_div_sh - {1'b0, r_b};
    assign w_div_ge      = ~w_div_diff[XLEN];
    assign w_div_acc_nxt = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_sh[XLEN-1:0];
    assign w_div_lo_nxt  = {r_lo[XLEN-2:0], w_div_ge};

    assign w_acc_nxt = r_op[2] ? w_div_acc_nxt : w_mul_acc_nxt;
    assign w_lo_nxt  = r_op[2] ? w_div_lo_nxt  : w_mul_lo_nxt;

    assign w_prod  = f_neg_2w({w_mul_acc_nxt, w_mul_lo_nxt}, r_neg);
    assign w_quo   = f_neg_w(w_div_lo_nxt, r_neg);
    assign w_rem   = f_neg_w(w_div_acc_nxt, r_neg);
    assign w_final = r_op[2] ? (r_op[1] ? w_rem : w_quo)
                             : ((r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = w_fast ? S_FINISH : S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_cnt == LAST_IT) w_state_nxt = S_FINISH;
            end
            S_FINISH: begin
                done = 1'b1;
                if (start) w_state_nxt = w_fast ? S_FINISH : S_CALC;
                else       w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op  <= funct3;
                r_a   <= w_abs_a;
                r_b   <= w_abs_b;
                r_neg <= w_neg;
                r_cnt <= '0;
                r_acc <= '0;
                r_lo  <= w_is_div ? w_abs_a : w_abs_b;
                if (w_fast) r_result <= w_fast_res;
            end else if ((r_state == S_CALC) && !flush) begin
                r_cnt <= r_cnt + 5'd1;
                r_acc <= w_acc_nxt;
                r_lo  <= w_lo_nxt;
                if (r_cnt == LAST_IT) r_result <= w_final;
            end
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised self-checking bench for muldiv_unit.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;
    int n_done   = 0;
    int exp_done = 0;
    logic overlap = 1'b0;

    muldiv_unit #(.XLEN(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done) n_done++;
        if (busy && done) overlap = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sbu;
        logic [63:0] ua, ub, p;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        sbu = {32'd0, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'd0: begin p = sa * sb;  return p[31:0];  end
            3'd1: begin p = sa * sb;  return p[63:32]; end
            3'd2: begin p = sa * sbu; return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return 32'h8000_0000;
                  else return $signed(a) / $signed(b);
            3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
            3'd6: if (b == 0) return a; else if (ovf) return 32'd0;
                  else return $signed(a) % $signed(b);
            default: if (b == 0) return a; else return a % b;
        endcase
    endfunction

    function automatic int m_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    // Issue one op; poke re-asserts start mid-CALC, which must be ignored.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit poke, output logic [31:0] res, output int lat, output int bcnt);
        @(negedge clock);
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
        @(posedge clock); #1;
        start = 1'b0; rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom);
        lat = -1; bcnt = 0; res = '0;
        exp_done++;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clock);
            if (poke && n == 5) start = 1'b1;
            if (poke && n == 6) start = 1'b0;
            if (busy) bcnt++;
            if (done) begin lat = n; res = result; break; end
        end
        start = 1'b0;
    endtask

    task automatic run_dir(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] res; int lat, bcnt;
        do_op(f, a, b, 1'b0, res, lat, bcnt);
        check({tag, "_res"}, 64'(res), 64'(exp_res));
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy"}, 64'(bcnt), 64'((exp_lat == 1) ? 0 : 32));
    endtask

    initial begin
        logic [31:0] res, a, b;
        logic [2:0]  f;
        int lat, bcnt, d0;
        logic [31:0] corners [5];
        corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        reset = 1'b0;

        run_dir("mul",    3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 33);
        run_dir("mulhu",  3'd3, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 33);
        run_dir("mulh",   3'd1, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33);
        run_dir("div",    3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33);
        run_dir("rem",    3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33);
        run_dir("divu",   3'd5, 32'hFFFF_FFF9, 32'h2, 32'h7FFF_FFFC, 33);
        run_dir("remu",   3'd7, 32'hFFFF_FFF9, 32'h2, 32'h0000_0001, 33);
        run_dir("div0",   3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_dir("remu0",  3'd7, 32'd5, 32'd0, 32'd5, 1);
        run_dir("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_dir("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

        // start during CALC is ignored: 6 * 7
        do_op(3'd0, 32'd6, 32'd7, 1'b1, res, lat, bcnt);
        check("poke_res", 64'(res), 64'd42);
        check("poke_lat", 64'(lat), 64'd33);

        // Back-to-back: MULHSU then DIVU accepted in the FINISH cycle
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, lat, bcnt);
        check("b2b_first_res", 64'(res), 64'hFFFF_FFFF);
        start = 1'b1; funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
        @(posedge clock); #1;
        start = 1'b0; rs1 = 32'hDEAD_BEEF; rs2 = 32'h0;
        exp_done++;
        lat = -1; bcnt = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clock);
            if (busy) bcnt++;
            if (done) begin lat = n; res = result; break; end
        end
        check("b2b_second_lat", 64'(lat), 64'd33);
        check("b2b_second_busy", 64'(bcnt), 64'd32);
        check("b2b_second_res", 64'(res), 64'd14);

        // Flush at T+10
        @(negedge clock);
        start = 1'b1; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd5;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(negedge clock);
        check("flush_busy_pre", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_busy_post", 64'(busy), 64'd0);
        d0 = n_done;
        repeat (40) @(negedge clock);
        check("flush_no_done", 64'(n_done - d0), 64'd0);
        check("flush_result", 64'(result), 64'd14);

        // Reset at T+10
        @(negedge clock);
        start = 1'b1; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd5;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        d0 = n_done;
        repeat (40) @(negedge clock);
        check("midrst_no_done", 64'(n_done - d0), 64'd0);

        // start and flush together: flush wins
        @(negedge clock);
        start = 1'b1; flush = 1'b1; funct3 = 3'd4; rs1 = 32'd5; rs2 = 32'd0;
        d0 = n_done;
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        check("sf_busy", 64'(busy), 64'd0);
        check("sf_done", 64'(done), 64'd0);
        repeat (40) @(negedge clock);
        check("sf_no_done", 64'(n_done - d0), 64'd0);

        // Randomised ops against the reference model
        for (int i = 0; i < 250; i++) begin
            f = 3'($urandom);
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 15) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            repeat ($urandom_range(0, 3)) @(negedge clock);
            do_op(f, a, b, 1'b0, res, lat, bcnt);
            check($sformatf("rnd%0d_f%0d_res", i, f), 64'(res), 64'(m_ref(f, a, b)));
            check($sformatf("rnd%0d_f%0d_lat", i, f), 64'(lat), 64'(m_lat(f, a, b)));
        end

        repeat (3) @(negedge clock);
        check("done_count", 64'(n_done), 64'(exp_done));
        check("busy_done_overlap", 64'(overlap), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
